// File: rtl/md5_sequencer.sv
// md5_sequencer: runs the 64-step MD5 compression on one 128-bit candidate
// message per job. The working state starts from the salt constants, and
// UNROLL steps are chained each clock. Once the job is finished, the result
// is compared against a captured target digest.
module md5_sequencer #(
  parameter int UNROLL = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_message,
  input  logic [127:0] target,
  input  logic         abort,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_digest,
  output logic         out_match,
  output logic         busy
);

  if (UNROLL != 1 && UNROLL != 2 && UNROLL != 4) begin : g_bad_unroll
    $error("md5_sequencer: UNROLL must be 1, 2 or 4");
  end

  localparam logic [31:0]  SALT_A = 32'h67452301;
  localparam logic [31:0]  SALT_B = 32'hefcdab89;
  localparam logic [31:0]  SALT_C = 32'h98badcfe;
  localparam logic [31:0]  SALT_D = 32'h10325476;
  localparam logic [127:0] SALT   = {SALT_A, SALT_B, SALT_C, SALT_D};
  localparam logic [5:0]   LAST_CNT = 6'(64 - UNROLL);
  localparam logic [5:0]   CNT_INC  = 6'(UNROLL);

  localparam logic [31:0] T_TAB [64] = '{
    32'hd76aa478, 32'he8c7b756, 32'h242070db, 32'hc1bdceee,
    32'hf57c0faf, 32'h4787c62a, 32'ha8304613, 32'hfd469501,
    32'h698098d8, 32'h8b44f7af, 32'hffff5bb1, 32'h895cd7be,
    32'h6b901122, 32'hfd987193, 32'ha679438e, 32'h49b40821,
    32'hf61e2562, 32'hc040b340, 32'h265e5a51, 32'he9b6c7aa,
    32'hd62f105d, 32'h02441453, 32'hd8a1e681, 32'he7d3fbc8,
    32'h21e1cde6, 32'hc33707d6, 32'hf4d50d87, 32'h455a14ed,
    32'ha9e3e905, 32'hfcefa3f8, 32'h676f02d9, 32'h8d2a4c8a,
    32'hfffa3942, 32'h8771f681, 32'h6d9d6122, 32'hfde5380c,
    32'ha4beea44, 32'h4bdecfa9, 32'hf6bb4b60, 32'hbebfbc70,
    32'h289b7ec6, 32'heaa127fa, 32'hd4ef3085, 32'h04881d05,
    32'hd9d4d039, 32'he6db99e5, 32'h1fa27cf8, 32'hc4ac5665,
    32'hf4292244, 32'h432aff97, 32'hab9423a7, 32'hfc93a039,
    32'h655b59c3, 32'h8f0ccc92, 32'hffeff47d, 32'h85845dd1,
    32'h6fa87e4f, 32'hfe2ce6e0, 32'ha3014314, 32'h4e0811a1,
    32'hf7537e82, 32'hbd3af235, 32'h2ad7d2bb, 32'heb86d391
  };

  // shift amounts indexed by {round, phase[1:0]}
  localparam logic [4:0] S_TAB [16] = '{
    5'd7, 5'd12, 5'd17, 5'd22,
    5'd5, 5'd9,  5'd14, 5'd20,
    5'd4, 5'd11, 5'd16, 5'd23,
    5'd6, 5'd10, 5'd15, 5'd21
  };

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t       state;
  logic [5:0]   cnt;
  logic [127:0] work;
  logic [127:0] msg_q;
  logic [127:0] tgt_q;
  logic [127:0] nxt;
  logic [127:0] digest;

  function automatic logic [31:0] rotl(input logic [31:0] x, input logic [4:0] n);
    logic [63:0] dbl;
    dbl = {x, x} << n;
    return dbl[63:32];
  endfunction

  // Padded block is {msg, 384'b0}; word 0 is the top 32 bits, so only
  // words 0..3 can be non-zero.
  function automatic logic [31:0] msg_word(input logic [127:0] msg, input logic [3:0] k);
    logic [31:0] w;
    case (k)
      4'd0:    w = msg[127:96];
      4'd1:    w = msg[95:64];
      4'd2:    w = msg[63:32];
      4'd3:    w = msg[31:0];
      default: w = 32'h0;
    endcase
    return w;
  endfunction

  function automatic logic [127:0] md5_step(input logic [127:0] st, input logic [5:0] s,
                                            input logic [127:0] msg);
    logic [31:0] a, b, c, d, f, sum;
    logic [3:0]  ph, k;
    logic [1:0]  rnd;
    a   = st[127:96];
    b   = st[95:64];
    c   = st[63:32];
    d   = st[31:0];
    rnd = s[5:4];
    ph  = s[3:0];
    case (rnd)
      2'd0: begin f = (b & c) | (~b & d); k = ph;                end
      2'd1: begin f = (d & b) | (~d & c); k = 4'd5 * ph + 4'd1;  end
      2'd2: begin f = b ^ c ^ d;          k = 4'd3 * ph + 4'd5;  end
      default: begin f = c ^ (b | ~d);    k = 4'd7 * ph;         end
    endcase
    sum = a + f + T_TAB[s] + msg_word(msg, k);
    return {d, b + rotl(sum, S_TAB[{rnd, ph[1:0]}]), b, c};
  endfunction

  // UNROLL steps chained combinationally from the current counter
  always_comb begin
    nxt = work;
    for (int u = 0; u < UNROLL; u++) begin
      nxt = md5_step(nxt, cnt + 6'(u), msg_q);
    end
    digest = {nxt[127:96] + SALT_A, nxt[95:64] + SALT_B,
              nxt[63:32]  + SALT_C, nxt[31:0]  + SALT_D};
  end

  // control FSM with registered handshake/status outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= 6'd0;
      work       <= 128'h0;
      msg_q      <= 128'h0;
      tgt_q      <= 128'h0;
      out_digest <= 128'h0;
      out_match  <= 1'b0;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // abort has no meaning here, so it does not block an accept
          if (in_valid) begin
            work     <= SALT;
            cnt      <= 6'd0;
            tgt_q    <= target;
            msg_q    <= in_message;
            state    <= RUN;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        RUN: begin
          if (abort) begin
            state    <= IDLE;
            cnt      <= 6'd0;
            in_ready <= 1'b1;
            busy     <= 1'b0;
          end else begin
            work <= nxt;
            if (cnt == LAST_CNT) begin
              cnt        <= 6'd0;
              out_digest <= digest;
              out_match  <= (digest == tgt_q);
              state      <= DONE;
              out_valid  <= 1'b1;
            end else begin
              cnt <= cnt + CNT_INC;
            end
          end
        end
        DONE: begin
          if (abort || out_ready) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          cnt       <= 6'd0;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_md5_sequencer.sv
// Bench for md5_sequencer: three instances (UNROLL 1/2/4) share stimulus.
// Expected results come from a loop-based MD5 model that derives its sine
// constants at run time. They are queued at accept, and a negedge monitor
// pops and compares them whenever an instance presents a result.
module tb_md5_sequencer;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic [127:0] in_message = '0;
  logic [127:0] target = '0;
  logic         abort = 1'b0;
  logic         out_ready = 1'b0;
  logic [2:0]   in_ready, out_valid, out_match, busy;
  logic [127:0] out_digest [3];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rdy_mode = 0;   // 0: always ready, 1: never, 2: random
  bit abort_en = 1'b0;

  typedef struct {
    logic [127:0] d;
    logic         m;
    int           acc;
  } exp_t;
  exp_t q [3][$];
  bit   pv [3];
  bit   hs [3];
  int   lat [3] = '{64, 32, 16};

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  md5_sequencer #(.UNROLL(1)) u1 (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[0]),
    .in_message(in_message), .target(target), .abort(abort), .out_valid(out_valid[0]),
    .out_ready(out_ready), .out_digest(out_digest[0]), .out_match(out_match[0]), .busy(busy[0]));
  md5_sequencer #(.UNROLL(2)) u2 (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[1]),
    .in_message(in_message), .target(target), .abort(abort), .out_valid(out_valid[1]),
    .out_ready(out_ready), .out_digest(out_digest[1]), .out_match(out_match[1]), .busy(busy[1]));
  md5_sequencer #(.UNROLL(4)) u4 (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[2]),
    .in_message(in_message), .target(target), .abort(abort), .out_valid(out_valid[2]),
    .out_ready(out_ready), .out_digest(out_digest[2]), .out_match(out_match[2]), .busy(busy[2]));

  // reference: textbook MD5 rounds over the block {m, 384'b0}
  function automatic logic [127:0] md5_ref(input logic [127:0] m);
    logic [511:0] pad;
    logic [31:0]  w [16];
    logic [31:0]  a, b, c, d, f, tmp, sum, t;
    int           g, sh;
    int           shifts [4][4] = '{'{7, 12, 17, 22}, '{5, 9, 14, 20},
                                    '{4, 11, 16, 23}, '{6, 10, 15, 21}};
    real          r;
    pad = {m, 384'b0};
    for (int j = 0; j < 16; j++) w[j] = pad[511 - 32*j -: 32];
    a = 32'h67452301; b = 32'hefcdab89; c = 32'h98badcfe; d = 32'h10325476;
    for (int i = 0; i < 64; i++) begin
      r = $sin(i + 1);
      if (r < 0.0) r = -r;
      t = 32'(longint'($floor(r * 4294967296.0)));
      case (i / 16)
        0: begin f = (b & c) | (~b & d); g = i;                end
        1: begin f = (d & b) | (~d & c); g = (5*i + 1) % 16;   end
        2: begin f = b ^ c ^ d;          g = (3*i + 5) % 16;   end
        default: begin f = c ^ (b | ~d); g = (7*i) % 16;       end
      endcase
      sh  = shifts[i/16][i%4];
      sum = a + f + t + w[g];
      tmp = d; d = c; c = b;
      b   = b + ((sum << sh) | (sum >> (32 - sh)));
      a   = tmp;
    end
    return {a + 32'h67452301, b + 32'hefcdab89, c + 32'h98badcfe, d + 32'h10325476};
  endfunction

  task automatic chk(input bit ok, input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0: out_ready = 1'b1;
      1: out_ready = 1'b0;
      default: out_ready = ($urandom_range(0, 7) != 0);
    endcase
  end

  // monitor / scoreboard
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        chk(in_ready[k] && !out_valid[k] && !busy[k] && !out_match[k],
            "reset_status", {in_ready[k], out_valid[k], busy[k], out_match[k]}, 4'b1000);
        chk(out_digest[k] == 128'h0, "reset_digest", out_digest[k], 128'h0);
        q[k].delete();
        pv[k] = 1'b0;
        hs[k] = 1'b0;
      end else begin
        if (hs[k]) chk(in_ready[k] && !out_valid[k], "idle_after_ready",
                       {in_ready[k], out_valid[k]}, 2'b10);
        hs[k] = 1'b0;
        if (abort && busy[k]) begin
          if (q[k].size() != 0) void'(q[k].pop_front());
          pv[k] = 1'b0;
        end else if (out_valid[k]) begin
          if (q[k].size() == 0) begin
            chk(1'b0, "unexpected_out_valid", k, 128'h0);
          end else begin
            chk(out_digest[k] == q[k][0].d, "digest", out_digest[k], q[k][0].d);
            chk(out_match[k] == q[k][0].m, "match", out_match[k], q[k][0].m);
            chk(!in_ready[k] && busy[k], "busy_in_done", {in_ready[k], busy[k]}, 2'b01);
            if (!pv[k]) chk(cyc - q[k][0].acc == lat[k], "latency", cyc - q[k][0].acc, lat[k]);
            pv[k] = 1'b1;
            if (out_ready) begin
              void'(q[k].pop_front());
              pv[k] = 1'b0;
              hs[k] = 1'b1;
            end
          end
        end
      end
    end
  end

  task automatic send(input logic [127:0] msg, input logic [127:0] tgt, input bit with_abort);
    int n = 0;
    exp_t e;
    forever begin
      @(posedge clk); #1;
      abort = 1'b0;
      in_valid = 1'b0;
      if (&in_ready) break;
      if (&busy && $urandom_range(0, 7) == 0) begin
        in_valid = 1'b1;
        in_message = {$urandom, $urandom, $urandom, $urandom};
      end
      if (abort_en && $urandom_range(0, 999) == 0) abort = 1'b1;
      if (++n > 3000) begin
        chk(1'b0, "send_timeout", in_ready, 3'b111);
        return;
      end
    end
    in_valid = 1'b1;
    in_message = msg;
    target = tgt;
    abort = with_abort;
    @(posedge clk); #1;
    e.d = md5_ref(msg);
    e.m = (e.d == tgt);
    e.acc = cyc;
    for (int k = 0; k < 3; k++) q[k].push_back(e);
    in_valid = 1'b0;
    abort = 1'b0;
    in_message = {$urandom, $urandom, $urandom, $urandom};
    target = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic wait_drain();
    int n = 0;
    while (!(q[0].size() == 0 && q[1].size() == 0 && q[2].size() == 0 && &in_ready)) begin
      @(negedge clk);
      if (++n > 1000) begin
        chk(1'b0, "drain_timeout", in_ready, 3'b111);
        break;
      end
    end
  endtask

  initial begin
    #1500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] m;
    int n;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // zero message, golden target; then target 0 (no match)
    rdy_mode = 0;
    send(128'h0, md5_ref(128'h0), 1'b0);
    wait_drain();
    send(128'h0, 128'h0, 1'b0);
    wait_drain();

    // hold result with out_ready low while in_valid pulses are ignored
    rdy_mode = 1;
    send(128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210, 128'h0, 1'b0);
    n = 0;
    while (!(&out_valid) && n < 200) begin @(negedge clk); n++; end
    chk(&out_valid, "hold_reach_done", out_valid, 3'b111);
    repeat (10) begin
      @(posedge clk); #1;
      in_valid = $urandom_range(0, 1);
      in_message = {$urandom, $urandom, $urandom, $urandom};
    end
    @(posedge clk); #1 in_valid = 1'b0;
    rdy_mode = 0;
    wait_drain();

    // abort after 20 steps of the UNROLL=1 job
    send(128'hdead_beef_0000_0000_0000_0000_cafe_f00d, 128'h0, 1'b0);
    repeat (20) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    @(negedge clk);
    chk(&in_ready && !(|out_valid), "idle_after_abort", {in_ready, out_valid}, 6'b111000);
    send(128'h1, md5_ref(128'h1), 1'b0);
    wait_drain();

    // abort together with in_valid in IDLE still accepts
    send(128'h5a5a, md5_ref(128'h5a5a), 1'b1);
    wait_drain();

    // reset at step 40, then back-to-back all-ones messages
    send(128'h7777, 128'h0, 1'b0);
    repeat (40) @(posedge clk);
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    m = '1;
    send(m, md5_ref(m), 1'b0);
    send(m, md5_ref(m), 1'b0);
    wait_drain();

    // random traffic
    rdy_mode = 2;
    abort_en = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      case ($urandom_range(0, 7))
        0: m = '0;
        1: m = '1;
        default: m = {$urandom, $urandom, $urandom, $urandom};
      endcase
      send(m, ($urandom_range(0, 1) != 0) ? md5_ref(m) : {$urandom, $urandom, $urandom, $urandom}, 1'b0);
    end
    abort_en = 1'b0;
    @(posedge clk); #1 abort = 1'b0;
    wait_drain();
    chk(q[0].size() + q[1].size() + q[2].size() == 0, "queues_empty",
        q[0].size() + q[1].size() + q[2].size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
